// File: rtl/cb_prefix_sequencer_if.sv
// Purpose: bundles the opcode handshake, register-file, memory, bit-ALU and flag
//          signals of the CB-prefix sequencer into a single port.
// Ports  : slave  = sequencer side (drives op_ready, rf_*, mem_* requests, alu_op/in, f_*, done, err)
//          master = core / register file / memory / ALU side (drives everything else)
interface cb_prefix_sequencer_if;
  logic        op_valid;
  logic [7:0]  op_byte;
  logic        op_ready;
  logic [2:0]  rf_sel;
  logic [7:0]  rf_rdata;
  logic        rf_we;
  logic [7:0]  rf_wdata;
  logic [15:0] hl;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [4:0]  alu_op;
  logic [7:0]  alu_in;
  logic        alu_c_in;
  logic [7:0]  alu_out;
  logic        alu_c;
  logic        alu_z;
  logic [3:0]  f_in;
  logic        f_we;
  logic [3:0]  f_out;
  logic        done;
  logic        err;

  modport slave (
    input  op_valid, op_byte, rf_rdata, hl, mem_rdata, mem_ack,
           alu_out, alu_c, alu_z, f_in,
    output op_ready, rf_sel, rf_we, rf_wdata, mem_addr, mem_rd, mem_wr, mem_wdata,
           alu_op, alu_in, alu_c_in, f_we, f_out, done, err
  );

  modport master (
    output op_valid, op_byte, rf_rdata, hl, mem_rdata, mem_ack,
           alu_out, alu_c, alu_z, f_in,
    input  op_ready, rf_sel, rf_we, rf_wdata, mem_addr, mem_rd, mem_wr, mem_wdata,
           alu_op, alu_in, alu_c_in, f_we, f_out, done, err
  );
endinterface

// File: rtl/cb_prefix_sequencer.sv
// Purpose : sequences one CB-page instruction (rotate/shift/SWAP/BIT/RES/SET) from opcode to writeback.
// Latency : register operand done 1 cycle after accept; (HL) = read wait + 1 (+ write wait if not BIT).
// Backpr. : op_ready only in IDLE; memory reads/writes hold until mem_ack (optional timeout).
// Ports   : clk, rst_n (async active-low), bus = cb_prefix_sequencer_if.slave.
// Option  : define CB_MEM_TIMEOUT_EN to abort a memory wait after TIMEOUT_CYCLES cycles with an err pulse.
module cb_prefix_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cb_prefix_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MEM_RD = 2'd2, MEM_WR = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;       // latched opcode
  logic [7:0]  opnd_q, opnd_d;   // byte read from (HL)
  logic [7:0]  res_q, res_d;     // ALU result waiting to be written to (HL)
  logic [15:0] addr_q, addr_d;   // HL captured at accept

  logic        is_mem, is_bit, is_shift;
  logic [7:0]  operand;
  logic        bit_z;
  logic        timeout;

  logic        op_ready, rf_we, mem_rd, mem_wr, f_we, done, err;
  logic [7:0]  rf_wdata, mem_wdata, alu_in;
  logic [15:0] mem_addr;
  logic [3:0]  f_out;

  assign is_mem   = (op_q[2:0] == 3'd6);
  assign is_bit   = (op_q[7:6] == 2'b01);
  assign is_shift = (op_q[7:6] == 2'b00);
  assign operand  = is_mem ? opnd_q : bus.rf_rdata;
  // BIT computes Z from the operand itself; the ALU zero flag is not trusted for it.
  assign bit_z    = ~operand[op_q[5:3]];

  // Only the carry of the incoming flags feeds the datapath.
  logic unused_flags;
  assign unused_flags = ^bus.f_in[3:1];

`ifdef CB_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_q, wait_d;

  // wait_q is 0 in the first wait cycle, so WAIT_LAST marks wait cycle TIMEOUT_CYCLES.
  assign timeout = (wait_q == WAIT_LAST);

  always_comb begin
    wait_d = '0;  // clears outside the wait states, hence on every entry
    if ((state_q == MEM_RD || state_q == MEM_WR) && !bus.mem_ack && !timeout)
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    addr_d    = addr_q;
    op_ready  = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    alu_in    = 8'h00;
    f_we      = 1'b0;
    f_out     = 4'h0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          op_d    = bus.op_byte;
          addr_d  = bus.hl;
          state_d = (bus.op_byte[2:0] == 3'd6) ? MEM_RD : EXEC;
        end
      end
      MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        if (bus.mem_ack) begin
          opnd_d  = bus.mem_rdata;
          state_d = EXEC;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      EXEC: begin
        alu_in = operand;
        if (is_shift) begin
          f_we  = 1'b1;
          f_out = {bus.alu_z, 1'b0, 1'b0, bus.alu_c};
        end else if (is_bit) begin
          f_we  = 1'b1;
          f_out = {bit_z, 1'b0, 1'b1, bus.f_in[0]};
        end
        if (is_mem && !is_bit) begin
          res_d   = bus.alu_out;
          state_d = MEM_WR;
        end else begin
          rf_we    = !is_mem && !is_bit;
          rf_wdata = rf_we ? bus.alu_out : 8'h00;
          done     = 1'b1;
          state_d  = IDLE;
        end
      end
      MEM_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = res_q;
        if (bus.mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      opnd_q  <= 8'h00;
      res_q   <= 8'h00;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.rf_sel    = op_q[2:0];
  assign bus.rf_we     = rf_we;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.alu_op    = {op_q[7:6], op_q[5:3]};
  assign bus.alu_in    = alu_in;
  assign bus.alu_c_in  = bus.f_in[0];
  assign bus.f_we      = f_we;
  assign bus.f_out     = f_out;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule

// File: tb/tb_cb_prefix_sequencer.sv
// Bench for cb_prefix_sequencer: register file, memory and bit-ALU models around the DUT,
// expected events queued at issue time and checked by an independent monitor.
module tb_cb_prefix_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cb_prefix_sequencer_if bus ();

  cb_prefix_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int EV_MRD = 1, EV_RFW = 2, EV_FW = 3, EV_MWR = 4, EV_DONE = 5, EV_ERR = 6;

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [7:0]  d;
    string       nm;
  } ev_t;

  ev_t  q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_edge = 0;

  // ---------------- environment models ----------------
  logic [7:0] regs [8];
  int         rd_dly = 1, wr_dly = 1, wait_n = 0, dly;
  logic       ack_m = 1'b0, spurious = 1'b0;
  logic [7:0] alu_o;
  logic       alu_co;

  assign bus.rf_rdata = regs[bus.rf_sel];
  assign bus.mem_ack  = ack_m | spurious;
  assign bus.alu_out  = alu_o;
  assign bus.alu_c    = alu_co;
  assign bus.alu_z    = (alu_o == 8'h00);

  always_comb begin
    alu_o  = bus.alu_in;
    alu_co = 1'b0;
    case (bus.alu_op[4:3])
      2'b00: case (bus.alu_op[2:0])
        3'd0: begin alu_o = {bus.alu_in[6:0], bus.alu_in[7]}; alu_co = bus.alu_in[7]; end
        3'd1: begin alu_o = {bus.alu_in[0], bus.alu_in[7:1]}; alu_co = bus.alu_in[0]; end
        3'd2: begin alu_o = {bus.alu_in[6:0], bus.alu_c_in};  alu_co = bus.alu_in[7]; end
        3'd3: begin alu_o = {bus.alu_c_in, bus.alu_in[7:1]};  alu_co = bus.alu_in[0]; end
        3'd4: begin alu_o = {bus.alu_in[6:0], 1'b0};          alu_co = bus.alu_in[7]; end
        3'd5: begin alu_o = {bus.alu_in[7], bus.alu_in[7:1]}; alu_co = bus.alu_in[0]; end
        3'd6: begin alu_o = {bus.alu_in[3:0], bus.alu_in[7:4]}; alu_co = 1'b0; end
        default: begin alu_o = {1'b0, bus.alu_in[7:1]};       alu_co = bus.alu_in[0]; end
      endcase
      2'b01:   alu_o = bus.alu_in;
      2'b10:   alu_o = bus.alu_in & ~(8'h01 << bus.alu_op[2:0]);
      default: alu_o = bus.alu_in | (8'h01 << bus.alu_op[2:0]);
    endcase
  end

  // Register file writes, cycle count and a memory that acks in wait cycle rd_dly/wr_dly (0 = never).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      regs[0] = 8'h85; regs[1] = 8'hFF; regs[2] = 8'h00; regs[3] = 8'h00;
      regs[4] = 8'h02; regs[5] = 8'h01; regs[6] = 8'h00; regs[7] = 8'hF0;
    end else if (bus.rf_we) begin
      regs[bus.rf_sel] = bus.rf_wdata;
    end
    #1;
    if (bus.mem_rd || bus.mem_wr) begin
      wait_n = wait_n + 1;
      dly    = bus.mem_rd ? rd_dly : wr_dly;
      ack_m  = (dly != 0) && (wait_n == dly);
    end else begin
      wait_n = 0;
      ack_m  = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic push(input string nm, input int k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h at cycle %0d, required no event", k, a, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.a != a || e.d != d) begin
        n_bad++;
        $display("FAIL %s: got kind=%0d a=%h d=%h, required kind=%0d a=%h d=%h",
                 e.nm, k, a, d, e.k, e.a, e.d);
      end
    end
  endtask

  // Monitor: events in a cycle are reported in the order MRD, RFW, FW, MWR, DONE, ERR.
  // DONE/ERR carry the cycle count since the accept edge (first cycle after accept = 1).
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd && bus.mem_wr) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_wr_exclusive: got mem_rd=1 mem_wr=1, required not both");
      end
      if (bus.mem_rd && bus.mem_ack) observe(EV_MRD, bus.mem_addr, 8'h00);
      if (bus.rf_we) observe(EV_RFW, {13'h0, bus.rf_sel}, bus.rf_wdata);
      if (bus.f_we) observe(EV_FW, 16'h0, {4'h0, bus.f_out});
      if (bus.mem_wr && bus.mem_ack) observe(EV_MWR, bus.mem_addr, bus.mem_wdata);
      if (bus.done) observe(EV_DONE, 16'(cyc - acc_edge + 1), 8'h00);
      if (bus.err) observe(EV_ERR, 16'(cyc - acc_edge + 1), 8'h00);
      if (bus.op_valid && bus.op_ready) acc_edge = cyc + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Presents op and returns in the drive phase just after the accept edge.
  task automatic issue(input logic [7:0] op, input bit hold);
    bit ok = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_byte  = op;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.op_ready) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept_%h: got op_ready=0 for 200 cycles, required accept", op);
    end
    @(posedge clk); #1;
    if (!hold) bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d events outstanding, required 0 (next: %s)", nm, q.size(), q[0].nm);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.op_valid  = 1'b0;
    bus.op_byte   = 8'h00;
    bus.hl        = 16'h0000;
    bus.f_in      = 4'h0;
    bus.mem_rdata = 8'h00;
    #1;
    chk("rst_op_ready", {31'h0, bus.op_ready}, 32'h1);
    chk("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {27'h0, bus.rf_we, bus.f_we, bus.mem_wr, bus.done, bus.err}, 32'h0);
    chk("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("rst_alu_op_sel", {24'h0, bus.alu_op, bus.rf_sel}, 32'h0);
    chk("rst_alu_in", {24'h0, bus.alu_in}, 32'h0);
    @(posedge clk); #1;

    // RLC B, B=0x85 -> 0x0B, C=1
    bus.f_in = 4'h0;
    push("rlc_b_rfw", EV_RFW, 16'd0, 8'h0B);
    push("rlc_b_flags", EV_FW, 16'h0, 8'h01);
    push("rlc_b_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h00, 1'b0);
    wait_idle("rlc_b");

    // BIT 7,(HL), byte 0x7F, ack in wait cycle 3, Cin=1
    bus.hl = 16'hC000; bus.mem_rdata = 8'h7F; rd_dly = 3; bus.f_in = 4'b0001;
    push("bit7_hl_rd", EV_MRD, 16'hC000, 8'h00);
    push("bit7_hl_flags", EV_FW, 16'h0, 8'h0B);
    push("bit7_hl_done", EV_DONE, 16'd4, 8'h00);
    issue(8'h7E, 1'b0);
    wait_idle("bit7_hl");

    // SET 0,(HL), byte 0x10 -> 0x11; HL changes after accept and must not matter
    bus.hl = 16'hD123; bus.mem_rdata = 8'h10; rd_dly = 1; wr_dly = 2; bus.f_in = 4'h0;
    push("set0_hl_rd", EV_MRD, 16'hD123, 8'h00);
    push("set0_hl_wr", EV_MWR, 16'hD123, 8'h11);
    push("set0_hl_done", EV_DONE, 16'd4, 8'h00);
    issue(8'hC6, 1'b0);
    bus.hl = 16'hFFFF;
    wait_idle("set0_hl");

    // SWAP A, A=0xF0 -> 0x0F
    push("swap_a_rfw", EV_RFW, 16'd7, 8'h0F);
    push("swap_a_flags", EV_FW, 16'h0, 8'h00);
    push("swap_a_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h37, 1'b0);
    wait_idle("swap_a");

    // SRA (HL), byte 0x81 -> 0xC0, C=1
    bus.hl = 16'h8001; bus.mem_rdata = 8'h81; rd_dly = 1; wr_dly = 1;
    push("sra_hl_rd", EV_MRD, 16'h8001, 8'h00);
    push("sra_hl_flags", EV_FW, 16'h0, 8'h01);
    push("sra_hl_wr", EV_MWR, 16'h8001, 8'hC0);
    push("sra_hl_done", EV_DONE, 16'd3, 8'h00);
    issue(8'h2E, 1'b0);
    wait_idle("sra_hl");

    // RES 3,C with a stray mem_ack held high the whole time
    spurious = 1'b1;
    push("res3_c_rfw", EV_RFW, 16'd1, 8'hF7);
    push("res3_c_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h99, 1'b0);
    wait_idle("res3_c");
    spurious = 1'b0;

    // BIT 0,D with D=0 -> Z=1, Cin=0
    push("bit0_d_flags", EV_FW, 16'h0, 8'h0A);
    push("bit0_d_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h42, 1'b0);
    wait_idle("bit0_d");

    // SRL L, L=0x01 -> 0x00, Z=1 C=1
    push("srl_l_rfw", EV_RFW, 16'd5, 8'h00);
    push("srl_l_flags", EV_FW, 16'h0, 8'h09);
    push("srl_l_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h3D, 1'b0);
    wait_idle("srl_l");

    // RR H, H=0x02, Cin=1 -> 0x81, C=0
    bus.f_in = 4'b0001;
    push("rr_h_rfw", EV_RFW, 16'd4, 8'h81);
    push("rr_h_flags", EV_FW, 16'h0, 8'h00);
    push("rr_h_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h1C, 1'b0);
    wait_idle("rr_h");

    // op_valid held high across a busy SET 0,(HL); RLC A (A=0x0F) only taken once idle
    bus.f_in = 4'h0; bus.hl = 16'h4000; bus.mem_rdata = 8'h10; rd_dly = 2; wr_dly = 2;
    push("held_set_rd", EV_MRD, 16'h4000, 8'h00);
    push("held_set_wr", EV_MWR, 16'h4000, 8'h11);
    push("held_set_done", EV_DONE, 16'd5, 8'h00);
    issue(8'hC6, 1'b1);
    push("held_rlc_a_rfw", EV_RFW, 16'd7, 8'h1E);
    push("held_rlc_a_flags", EV_FW, 16'h0, 8'h00);
    push("held_rlc_a_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h07, 1'b0);
    wait_idle("held");

    // RLC (HL) with the write never acked; reset lands mid MEM_WR
    bus.hl = 16'h1234; bus.mem_rdata = 8'h80; rd_dly = 1; wr_dly = 0;
    push("rst_mid_rd", EV_MRD, 16'h1234, 8'h00);
    push("rst_mid_flags", EV_FW, 16'h0, 8'h01);
    issue(8'h06, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_wr) break;
    end
    chk("rst_mid_wr_seen", {31'h0, bus.mem_wr}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_drop", {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_mid_op_ready", {31'h0, bus.op_ready}, 32'h1);
    chk("rst_mid_no_done", {30'h0, bus.done, bus.rf_we}, 32'h0);
    chk("rst_mid_queue", q.size(), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // After reset the register file is fresh again: RLC B, B=0x85
    push("post_rst_rfw", EV_RFW, 16'd0, 8'h0B);
    push("post_rst_flags", EV_FW, 16'h0, 8'h01);
    push("post_rst_done", EV_DONE, 16'd1, 8'h00);
    issue(8'h00, 1'b0);
    wait_idle("post_rst");

`ifdef CB_MEM_TIMEOUT_EN
    // SWAP (HL) with no ack at all: err in wait cycle 15, nothing written
    bus.hl = 16'h2000; rd_dly = 0;
    push("timeout_err", EV_ERR, 16'd15, 8'h00);
    issue(8'h36, 1'b0);
    wait_idle("timeout");
    chk("timeout_op_ready", {31'h0, bus.op_ready}, 32'h1);
    chk("timeout_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
`endif

    repeat (3) @(posedge clk);
    chk("final_queue_empty", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 time units, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cb_prefix_sequencer.md
Name: cb_prefix_sequencer

Overview:
- Multi-cycle sequencer for the CB-prefixed instruction page: rotates, shifts, SWAP, BIT, RES and SET.
- Accepts the CB opcode byte after the core has fetched it.
- Encodes the opcode into the 5-bit shift_op command for the bit-operation ALU and fetches the operand from the register file or from memory at (HL).
- Writes the result back and updates the Z/N/H/C flags.
- Sits between the core's fetch/decode stage and the register file, bit ALU and memory bus.

Parameters:
- TIMEOUT_CYCLES, 15: maximum mem_ack wait in MEM_RD/MEM_WR. Only used when CB_MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  CB opcode byte present on op_byte.
- op_byte  in  8  CB opcode byte.
- op_ready  out  1  sequencer can accept an opcode.
- rf_sel  out  3  register select: 0=B 1=C 2=D 3=E 4=H 5=L 7=A. Driven from latched opcode bits [2:0].
- rf_rdata  in  8  combinational register-file read data.
- rf_we  out  1  register write strobe.
- rf_wdata  out  8  register write data.
- hl  in  16  current HL value.
- mem_addr  out  16  memory address.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory handshake acknowledge.
- alu_op  out  5  shift_op command to the bit ALU.
- alu_in  out  8  ALU operand.
- alu_c_in  out  1  carry into the ALU; equals f_in[0].
- alu_out  in  8  ALU result.
- alu_c  in  1  ALU carry out.
- alu_z  in  1  ALU zero flag.
- f_in  in  4  current flags {Z,N,H,C}.
- f_we  out  1  flag write strobe.
- f_out  out  4  new flags {Z,N,H,C}.
- done  out  1  one-cycle pulse when the instruction retires.
- err  out  1  one-cycle pulse on memory timeout; tied 0 without CB_MEM_TIMEOUT_EN.

Behaviour:
- Reset: asynchronous on rst_n low; state=IDLE; opcode register and operand latch = 0.
  - All outputs 0, except op_ready=1 once in IDLE.
  - rst_n low in any state aborts immediately; no write strobe may assert after reset.
- States: IDLE, EXEC, MEM_RD, MEM_WR.
- IDLE: op_ready=1.
  - op_valid=1 latches op_byte.
  - If op_byte[2:0]==6 (operand is (HL)), go to MEM_RD; otherwise go to EXEC.
- Opcode encoding: alu_op = {op[7:6], op[5:3]}.
  - Group 00 = rotate/shift with sub-op op[5:3]: RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL.
  - Group 01 = BIT, 10 = RES, 11 = SET; op[5:3] is the bit index.
- MEM_RD:
  - mem_rd=1, mem_addr=hl sampled at opcode acceptance and held.
  - Stay until mem_ack=1; then latch mem_rdata and go to EXEC.
- EXEC, exactly one cycle:
  - alu_in = rf_rdata for register operands; latched memory byte for (HL).
  - Register operand, non-BIT: rf_we=1, rf_wdata=alu_out.
  - (HL) operand, non-BIT: go to MEM_WR.
  - Register operand, or BIT on either operand: done=1, then IDLE.
- MEM_WR:
  - mem_wr=1, mem_addr=hl, mem_wdata = alu_out captured in EXEC.
  - On mem_ack: done=1, then IDLE.
- Flags (f_we pulses in EXEC only):
  - Group 00: f_out = {alu_z, 0, 0, alu_c}.
  - BIT: f_out = {~alu_in[op[5:3]], 0, 1, f_in[0]}. Z is computed locally; alu_z is ignored.
  - RES/SET: f_we=0.
- Latency, measured from the accept edge to the done pulse:
  - Register operand: done in the first cycle after accept.
  - (HL) BIT: read wait + 1 cycle.
  - (HL) other: read wait + 1 cycle + write wait.
- Boundaries:
  - op_valid while not IDLE is ignored; op_ready=0.
  - mem_rd and mem_wr are never asserted together.
  - mem_ack outside MEM_RD/MEM_WR is ignored.
  - mem_ack in the same cycle as the request assertion is accepted; minimum wait is 1 cycle.

Optional Feature:
- Macro: CB_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to MEM_RD/MEM_WR.
  - If TIMEOUT_CYCLES cycles pass without mem_ack: err=1 for one cycle, return to IDLE, no register, memory or flag write, no done.
- Undefined: waits forever; err tied to 0; no counter logic.

Test Plan:
- Reset mid MEM_WR (op 0x06, RLC (HL)) -> mem_wr drops asynchronously; state IDLE, op_ready=1; no done.
- op 0x00 (RLC B), B=0x85, C=0 -> alu_op=00000; rf_we, rf_wdata=0x0B; f_out={0,0,0,1}; done the first cycle after accept.
- op 0x7E (BIT 7,(HL)), hl=0xC000, mem_rdata=0x7F, ack after 3 cycles -> mem_addr=0xC000; f_out={1,0,1,Cin}; no mem_wr; done.
- op 0xC6 (SET 0,(HL)), mem_rdata=0x10 -> mem_wr with mem_wdata=0x11; f_we=0; done after write ack.
- op_valid held high across a busy instruction -> second opcode accepted only in IDLE; one done per accepted opcode.
- CB_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15, op 0x36 (SWAP (HL)), no ack -> err pulse at wait cycle 15; no writes; op_ready=1 next cycle.
